// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 FP32 max-pool over a raster pixel stream, floor pooling on odd
// dimensions, optional ReLU on the pooled value. No backpressure.
module max_pool_2x2 #(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_WIDTH  = 56,
   parameter int IMG_HEIGHT = 56,
   parameter bit RELU_EN    = 1'b0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  data_valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out_pixel,
   output logic                  done
);

   localparam int BUF_DEPTH = IMG_WIDTH / 2;
   localparam int COL_W     = (IMG_WIDTH > 1)  ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int BIDX_W    = (BUF_DEPTH > 1)  ? $clog2(BUF_DEPTH)  : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam bit ODD_W = (IMG_WIDTH % 2) == 1;
   localparam bit ODD_H = (IMG_HEIGHT % 2) == 1;
   localparam int SB    = DATA_WIDTH - 1;

   // Strict sign-magnitude "x > y"; +0 and -0 are equal, so ties keep the earlier operand.
   function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] x, input logic [DATA_WIDTH-1:0] y);
      logic both_zero;
      both_zero = (x[SB-1:0] == '0) && (y[SB-1:0] == '0);
      if (both_zero)
         return 1'b0;
      else if (x[SB] != y[SB])
         return y[SB];
      else if (!x[SB])
         return x[SB-1:0] > y[SB-1:0];
      else
         return x[SB-1:0] < y[SB-1:0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
      return fp_gt(b, a) ? b : a;
   endfunction

   logic [COL_W-1:0]      col_q, col_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] lbuf_q [BUF_DEPTH];

   logic                  last_col, last_row, in_win, lbuf_we;
   logic [BIDX_W-1:0]     bidx;
   logic [DATA_WIDTH-1:0] lbuf_rd, pooled;

   assign last_col = (col_q == COL_LAST);
   assign last_row = (row_q == ROW_LAST);
   // Trailing odd column/row only advance the counters.
   assign in_win   = !(ODD_W && last_col) && !(ODD_H && last_row);
   assign bidx     = BIDX_W'(col_q >> 1);
   assign lbuf_rd  = lbuf_q[bidx];
   assign pooled   = fp_max(fp_max(lbuf_rd, hold_q), data_in);
   assign lbuf_we  = data_valid_in && in_win && col_q[0] && !row_q[0];

   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      hold_d     = hold_q;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      if (data_valid_in) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
         if (in_win) begin
            if (!col_q[0]) begin
               hold_d = data_in;
            end else if (row_q[0]) begin
               data_out_d = (RELU_EN && pooled[SB]) ? '0 : pooled;
               valid_d    = 1'b1;
            end
         end
         done_d = last_col && last_row;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         col_q      <= '0;
         row_q      <= '0;
         hold_q     <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         hold_q     <= hold_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
      end
   end

   // Row-pair partial maxima; contents are always rewritten by an even row before use.
   always_ff @(posedge clk) begin
      if (lbuf_we)
         lbuf_q[bidx] <= fp_max(hold_q, data_in);
   end

   assign data_out        = data_out_q;
   assign valid_out_pixel = valid_q;
   assign done            = done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench: four max_pool_2x2 instances (4x4, 2x2, 2x2+ReLU, 5x5) fed
// directed frames; a negedge monitor pops expected {valid,data,done} per event.
module tb_max_pool_2x2;

   typedef struct packed {
      logic        vld;
      logic [31:0] data;
      logic        dn;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic [3:0]  vin = '0;
   logic [31:0] din = '0;
   logic [31:0] dout [4];
   logic        vout [4];
   logic        dn   [4];

   exp_t        q0[$], q1[$], q2[$], q3[$];
   logic [31:0] pix_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          fin_req = 1'b0;
   bit          mon_done = 1'b0;

   always #5 clk = ~clk;

   max_pool_2x2 #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4), .RELU_EN(1'b0)) u0 (
      .clk(clk), .resetn(resetn), .data_valid_in(vin[0]), .data_in(din),
      .data_out(dout[0]), .valid_out_pixel(vout[0]), .done(dn[0]));
   max_pool_2x2 #(.DATA_WIDTH(32), .IMG_WIDTH(2), .IMG_HEIGHT(2), .RELU_EN(1'b0)) u1 (
      .clk(clk), .resetn(resetn), .data_valid_in(vin[1]), .data_in(din),
      .data_out(dout[1]), .valid_out_pixel(vout[1]), .done(dn[1]));
   max_pool_2x2 #(.DATA_WIDTH(32), .IMG_WIDTH(2), .IMG_HEIGHT(2), .RELU_EN(1'b1)) u2 (
      .clk(clk), .resetn(resetn), .data_valid_in(vin[2]), .data_in(din),
      .data_out(dout[2]), .valid_out_pixel(vout[2]), .done(dn[2]));
   max_pool_2x2 #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5), .RELU_EN(1'b0)) u3 (
      .clk(clk), .resetn(resetn), .data_valid_in(vin[3]), .data_in(din),
      .data_out(dout[3]), .valid_out_pixel(vout[3]), .done(dn[3]));

   // Small positive integer to FP32 bit pattern, used only to build stimulus.
   function automatic logic [31:0] i2f(input int n);
      int          e;
      logic [31:0] m;
      e = 0;
      for (int b = 0; b < 31; b++)
         if (((n >> b) & 1) == 1) e = b;
      m = 32'(n) << (23 - e);
      return {1'b0, 8'(127 + e), m[22:0]};
   endfunction

   task automatic push_exp(input int id, input logic v, input logic [31:0] d, input logic f);
      exp_t e;
      e = '{vld: v, data: d, dn: f};
      case (id)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endtask

   function automatic int qsz(input int id);
      case (id)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   task automatic load_seq(input int n, input bit neg);
      for (int k = 1; k <= n; k++)
         pix_q.push_back(i2f(k) | {neg, 31'h0});
   endtask

   task automatic feed(input logic [3:0] mask, input bit gaps);
      for (int i = 0; i < pix_q.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(2, 0)) begin
               vin = '0;
               din = 32'hdeadbeef;
               @(posedge clk); #1;
            end
         end
         din = pix_q[i];
         vin = mask;
         @(posedge clk); #1;
      end
      vin = '0;
      pix_q.delete();
   endtask

   task automatic drain();
      repeat (8) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      bit   ok;
      for (int id = 0; id < 4; id++) begin
         if (!resetn) begin
            n_tests++;
            if (dout[id] != 32'h0 || vout[id] || dn[id]) begin
               n_fail++;
               $display("FAIL reset_out dut%0d: got data=%h valid=%b done=%b, want 00000000/0/0",
                        id, dout[id], vout[id], dn[id]);
            end
         end else if (vout[id] || dn[id]) begin
            n_tests++;
            if (qsz(id) == 0) begin
               n_fail++;
               $display("FAIL unexpected_out dut%0d: got valid=%b data=%h done=%b, want no event",
                        id, vout[id], dout[id], dn[id]);
            end else begin
               case (id)
                  0: e = q0.pop_front();
                  1: e = q1.pop_front();
                  2: e = q2.pop_front();
                  default: e = q3.pop_front();
               endcase
               ok = (vout[id] == e.vld) && (dn[id] == e.dn) && (!e.vld || dout[id] == e.data);
               if (!ok) begin
                  n_fail++;
                  $display("FAIL pooled_out dut%0d: got valid=%b data=%h done=%b, want valid=%b data=%h done=%b",
                           id, vout[id], dout[id], dn[id], e.vld, e.data, e.dn);
               end
            end
         end
      end
      if (fin_req && !mon_done) begin
         for (int id = 0; id < 4; id++) begin
            n_tests++;
            if (qsz(id) != 0) begin
               n_fail++;
               $display("FAIL missing_out dut%0d: got %0d expected events never seen, want 0",
                        id, qsz(id));
            end
         end
         mon_done = 1'b1;
      end
   end

   initial begin
      #2 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;

      // 4x4 ramp 1..16
      push_exp(0, 1, 32'h40c00000, 0);
      push_exp(0, 1, 32'h41000000, 0);
      push_exp(0, 1, 32'h41600000, 0);
      push_exp(0, 1, 32'h41800000, 1);
      load_seq(16, 0);
      feed(4'b0001, 0);
      drain();

      // 2x2 all-negative, with and without ReLU
      push_exp(1, 1, 32'hbf000000, 1);
      push_exp(2, 1, 32'h00000000, 1);
      pix_q = '{32'hbf800000, 32'hc0000000, 32'hc0400000, 32'hbf000000};
      feed(4'b0110, 0);
      drain();

      // -0/+0 ties keep the earlier operand; ReLU clears -0
      push_exp(1, 1, 32'h80000000, 1);
      push_exp(2, 1, 32'h00000000, 1);
      pix_q = '{32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000};
      feed(4'b0110, 0);
      drain();

      // mixed signs; positive passes ReLU untouched
      push_exp(1, 1, 32'h3f000000, 1);
      pix_q = '{32'hc0000000, 32'h3f000000, 32'hbf800000, 32'h00000000};
      feed(4'b0010, 0);
      push_exp(2, 1, 32'h40800000, 1);
      pix_q = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};
      feed(4'b0100, 0);
      drain();

      // 4x4 ramp with random idle gaps
      push_exp(0, 1, 32'h40c00000, 0);
      push_exp(0, 1, 32'h41000000, 0);
      push_exp(0, 1, 32'h41600000, 0);
      push_exp(0, 1, 32'h41800000, 1);
      load_seq(16, 0);
      feed(4'b0001, 1);
      drain();

      // 5x5: floor pooling, done arrives alone after pixel 25
      push_exp(3, 1, 32'h40e00000, 0);
      push_exp(3, 1, 32'h41100000, 0);
      push_exp(3, 1, 32'h41880000, 0);
      push_exp(3, 1, 32'h41980000, 0);
      push_exp(3, 0, 32'h0, 1);
      load_seq(25, 0);
      feed(4'b1000, 0);
      drain();

      // partial frame aborted by reset, then a clean frame
      load_seq(6, 0);
      feed(4'b0001, 0);
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      push_exp(0, 1, 32'h40c00000, 0);
      push_exp(0, 1, 32'h41000000, 0);
      push_exp(0, 1, 32'h41600000, 0);
      push_exp(0, 1, 32'h41800000, 1);
      load_seq(16, 0);
      feed(4'b0001, 0);
      drain();

      // back-to-back frames, second one negated
      push_exp(0, 1, 32'h40c00000, 0);
      push_exp(0, 1, 32'h41000000, 0);
      push_exp(0, 1, 32'h41600000, 0);
      push_exp(0, 1, 32'h41800000, 1);
      push_exp(0, 1, 32'hbf800000, 0);
      push_exp(0, 1, 32'hc0400000, 0);
      push_exp(0, 1, 32'hc1100000, 0);
      push_exp(0, 1, 32'hc1300000, 1);
      load_seq(16, 0);
      load_seq(16, 1);
      feed(4'b0001, 0);
      drain();

      fin_req = 1'b1;
      for (int i = 0; i < 10 && !mon_done; i++) @(posedge clk);
      #1;
      if (!mon_done) begin
         n_tests++;
         n_fail++;
         $display("FAIL monitor_final: got no final queue check, want one");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
